// File: rtl/wb_nic_arb.sv
// Registered Wishbone slave-select interconnect: one master, 2**ADDR_SEL_WIDTH slaves.
// Define WB_NIC_TIMEOUT_EN to enable the WAIT-state watchdog that errors slaves which never ack.
module wb_nic_arb #(
  parameter int unsigned ADDR_SEL_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [(1<<ADDR_SEL_WIDTH)-1:0] SLAVE_MASK = 16'h0007,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                               i_clk,
  input  logic                                               i_reset,
  input  logic [ADDR_WIDTH-1:0]                              i_wb_adr,
  input  logic                                               i_wb_cyc,
  input  logic                                               i_wb_stb,
  output logic                                               o_wb_ack,
  output logic                                               o_wb_err,
  output logic [DATA_WIDTH-1:0]                              o_wb_dat,
  output logic [(1<<ADDR_SEL_WIDTH)-1:0]                     o_slave_sel,
  input  logic [(1<<ADDR_SEL_WIDTH)-1:0]                     i_slave_ack,
  input  logic [(1<<ADDR_SEL_WIDTH)-1:0][DATA_WIDTH-1:0]     i_slave_rdata,
  output logic                                               o_busy
);
  localparam int unsigned N = 1 << ADDR_SEL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  logic [ADDR_SEL_WIDTH-1:0] r_idx;
  logic [N-1:0]              r_slave_sel;
  logic                      r_ack;
  logic                      r_err;
  logic [DATA_WIDTH-1:0]     r_dat;
`ifdef WB_NIC_TIMEOUT_EN
  logic [15:0]               r_wdog;
`endif

  logic                      w_req;
  logic [ADDR_SEL_WIDTH-1:0] w_idx;
  logic [N-1:0]              w_onehot;
  logic                      w_sack;
  logic [DATA_WIDTH-1:0]     w_srdata;
  logic                      w_unused_adr;

  assign w_req        = i_wb_cyc & i_wb_stb;
  assign w_idx        = i_wb_adr[ADDR_WIDTH-1 -: ADDR_SEL_WIDTH];
  assign w_unused_adr = ^i_wb_adr[ADDR_WIDTH-ADDR_SEL_WIDTH-1:0];
  // Only the latched target's ack/data is observed; other slaves' acks are ignored.
  assign w_sack       = i_slave_ack[r_idx];
  assign w_srdata     = i_slave_rdata[r_idx];

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_slave_sel <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dat       <= '0;
`ifdef WB_NIC_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx <= w_idx;
            if (SLAVE_MASK[w_idx]) begin
              r_slave_sel <= w_onehot;
              r_state     <= S_WAIT;
`ifdef WB_NIC_TIMEOUT_EN
              r_wdog      <= '0;
`endif
            end else begin
              r_err   <= 1'b1;
              r_dat   <= ERR_DATA;
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          // Abort takes priority over a same-cycle slave ack.
          if (!i_wb_cyc) begin
            r_slave_sel <= '0;
            r_state     <= S_IDLE;
          end else if (w_sack) begin
            r_dat       <= w_srdata;
            r_ack       <= 1'b1;
            r_slave_sel <= '0;
            r_state     <= S_RESP;
          end
`ifdef WB_NIC_TIMEOUT_EN
          else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
            r_err       <= 1'b1;
            r_dat       <= ERR_DATA;
            r_slave_sel <= '0;
            r_state     <= S_RESP;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_slave_sel <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wb_ack    = r_ack;
  assign o_wb_err    = r_err;
  assign o_wb_dat    = r_dat;
  assign o_slave_sel = r_slave_sel;
  assign o_busy      = (r_state != S_IDLE);

endmodule
